kbd_event_queue: RTL and testbench
==================================

KBD_EVENT_QUEUE -- requirements
Module: kbd_event_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning FIFO depth is 2**DEPTH_LOG2 entries.
REQ-002 SHALL have port clk_sys, input, 1, the only clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port kbd_mouse_level, input, 1, event strobe; each toggle marks one new event.
REQ-005 SHALL have port kbd_mouse_type, input, 2, event type: 0 = mouse X, 1 = mouse Y, 2 = keyboard, 3 = OSD keyboard.
REQ-006 SHALL have port kbd_mouse_data, input, 8, event payload.
REQ-007 SHALL have port mouse_x, output, 8, wrapping X position counter.
REQ-008 SHALL have port mouse_y, output, 8, wrapping Y position counter.
REQ-009 SHALL have port kbd_valid, output, 1, keyboard byte presented.
REQ-010 SHALL have port kbd_data, output, 8, keyboard byte.
REQ-011 SHALL have port kbd_osd, output, 1, set when the presented byte is type 3.
REQ-012 SHALL have port kbd_ack, input, 1, consumer accepts the presented byte.
REQ-013 SHALL have port overflow, output, 1, sticky flag for a dropped event.
REQ-014 SHALL have port level, output, DEPTH_LOG2+1, current FIFO occupancy.

Function
REQ-015 SHALL register kbd_mouse_level once into lvl_q; a push occurs in any cycle where kbd_mouse_level != lvl_q.
REQ-016 A push SHALL write {kbd_mouse_type, kbd_mouse_data}, sampled in that same cycle, at the write pointer.
REQ-017 Pointers SHALL be DEPTH_LOG2+1 bits wide and wrap naturally.
- Full: MSBs differ and the low bits are equal.
- Empty: the pointers are equal.
REQ-018 A push while full SHALL be dropped and SHALL set overflow; FIFO contents and pointers are unchanged.
REQ-019 A push and a pop in the same cycle SHALL both take effect; level is unchanged.
REQ-020 When full, a simultaneous push and pop SHALL be accepted without setting overflow.
REQ-021 The dispatcher SHALL be a state machine with states IDLE, EXEC and KBD_WAIT.
REQ-022 IDLE: if the FIFO is not empty, the dispatcher SHALL pop the head into a head register and go to EXEC; otherwise it stays in IDLE.
REQ-023 EXEC, type 0: mouse_x <= mouse_x + data, as 8-bit two's-complement with wrap; then go to IDLE.
REQ-024 EXEC, type 1: mouse_y <= mouse_y + data, same arithmetic as REQ-023; then go to IDLE.
REQ-025 EXEC, type 2 or 3: on the next edge the dispatcher SHALL drive kbd_data <= data, kbd_osd <= type[0], kbd_valid <= 1, and go to KBD_WAIT.
REQ-026 KBD_WAIT: kbd_data and kbd_osd SHALL be held stable while kbd_valid = 1.
REQ-027 KBD_WAIT: in a cycle where kbd_ack = 1, the dispatcher SHALL clear kbd_valid on that edge and go to IDLE.
REQ-028 kbd_ack SHALL be ignored in IDLE and EXEC.
REQ-029 Latency, mouse event: the counter changes on the 3rd clock edge after the edge that samples the toggle (edge 1 pushes, edge 2 pops, edge 3 updates).
REQ-030 Latency, keyboard event: kbd_valid rises on the 3rd edge after the edge that samples the toggle.
REQ-031 Back-to-back mouse events SHALL sustain 1 event per 2 cycles.
REQ-032 A keyboard byte SHALL block later events (head-of-line) until acknowledged; order of all events SHALL be preserved.
REQ-033 Pushes SHALL continue while the dispatcher is in KBD_WAIT.
REQ-034 overflow SHALL be cleared only by reset.
REQ-035 level SHALL equal wr_ptr - rd_ptr, registered, and SHALL be exact every cycle.

Reset
REQ-036 In any cycle with reset = 1, regardless of state, the block SHALL set:
- state = IDLE
- both pointers = 0, so level = 0
- mouse_x = mouse_y = 0
- kbd_valid = 0, kbd_data = 0, kbd_osd = 0
- overflow = 0
- lvl_q <= kbd_mouse_level
REQ-037 Because of REQ-036, no push SHALL occur in the first cycle after reset deasserts.
REQ-038 Reset asserted during KBD_WAIT SHALL drop the pending byte without an ack.
REQ-039 FIFO RAM contents SHALL need no reset.

Verification
REQ-040 Mouse X: toggle with type 0, data 8'h05 -> mouse_x = 8'h05 three edges later; then toggle with type 0, data 8'hFB -> mouse_x = 8'h00.
REQ-041 Keyboard with ack hold: toggle with type 3, data 8'h45, ack held low for 10 cycles -> kbd_valid = 1, kbd_data = 8'h45, kbd_osd = 1, all stable for 10 cycles; one-cycle ack -> kbd_valid = 0 on the next edge.
REQ-042 Ordering: keyboard 8'h20 with no ack, then three mouse Y events of data 1 -> mouse_y stays 0 and level = 3; after ack -> mouse_y = 3, updating on alternate cycles.
REQ-043 Overflow: DEPTH_LOG2 = 3, no ack, 10 keyboard toggles -> one in the head register, 8 in the FIFO (level = 8), the 10th dropped, overflow = 1; after 9 acks the bytes arrive in order.
REQ-044 Reset in KBD_WAIT: reset for 1 cycle while kbd_valid = 1 and level = 4 -> kbd_valid = 0, level = 0, counters = 0, overflow = 0, and no spurious push afterwards.
REQ-045 Full push/pop: FIFO full, toggle arrives on the same edge the dispatcher pops -> the event is accepted, overflow stays 0, level stays 8.

Source files
------------

// File: rtl/kbd_event_queue.sv
// Keyboard/mouse event queue: toggle-strobed events go into a small FIFO and are
// dispatched in order to wrapping mouse counters or a valid/ack keyboard port.
module kbd_event_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  kbd_mouse_level,
  input  logic [1:0]            kbd_mouse_type,
  input  logic [7:0]            kbd_mouse_data,
  output logic [7:0]            mouse_x,
  output logic [7:0]            mouse_y,
  output logic                  kbd_valid,
  output logic [7:0]            kbd_data,
  output logic                  kbd_osd,
  input  logic                  kbd_ack,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    KBD_WAIT = 2'd2
  } state_e;

  logic [9:0]          mem_q [DEPTH];
  state_e              state_q, state_d;
  logic                lvl_q;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [9:0]          head_q, head_d;
  logic [7:0]          mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [7:0]          kbd_data_q, kbd_data_d;
  logic                kbd_valid_q, kbd_valid_d, kbd_osd_q, kbd_osd_d;
  logic                overflow_q, overflow_d;
  logic                push_req_s, push_s, pop_s, full_s, empty_s;

  always_comb begin
    push_req_s = (kbd_mouse_level != lvl_q);
    empty_s    = (wr_ptr_q == rd_ptr_q);
    full_s     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    pop_s      = (state_q == IDLE) && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s     = push_req_s && (!full_s || pop_s);

    state_d     = state_q;
    head_d      = head_q;
    mouse_x_d   = mouse_x_q;
    mouse_y_d   = mouse_y_q;
    kbd_valid_d = kbd_valid_q;
    kbd_data_d  = kbd_data_q;
    kbd_osd_d   = kbd_osd_q;

    case (state_q)
      IDLE: begin
        if (pop_s) begin
          head_d  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        case (head_q[9:8])
          2'd0: begin
            mouse_x_d = mouse_x_q + head_q[7:0];
            state_d   = IDLE;
          end
          2'd1: begin
            mouse_y_d = mouse_y_q + head_q[7:0];
            state_d   = IDLE;
          end
          default: begin
            kbd_data_d  = head_q[7:0];
            kbd_osd_d   = head_q[8];
            kbd_valid_d = 1'b1;
            state_d     = KBD_WAIT;
          end
        endcase
      end
      KBD_WAIT: begin
        if (kbd_ack) begin
          kbd_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = KBD_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d    = wr_ptr_d - rd_ptr_d;
    overflow_d = overflow_q | (push_req_s & ~push_s);
  end

  always_ff @(posedge clk_sys) begin
    lvl_q <= kbd_mouse_level;
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_q      <= 10'd0;
      mouse_x_q   <= 8'd0;
      mouse_y_q   <= 8'd0;
      kbd_valid_q <= 1'b0;
      kbd_data_q  <= 8'd0;
      kbd_osd_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      mouse_x_q   <= mouse_x_d;
      mouse_y_q   <= mouse_y_d;
      kbd_valid_q <= kbd_valid_d;
      kbd_data_q  <= kbd_data_d;
      kbd_osd_q   <= kbd_osd_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_sys) begin
    if (push_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {kbd_mouse_type, kbd_mouse_data};
    end
  end

  assign mouse_x   = mouse_x_q;
  assign mouse_y   = mouse_y_q;
  assign kbd_valid = kbd_valid_q;
  assign kbd_data  = kbd_data_q;
  assign kbd_osd   = kbd_osd_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_kbd_event_queue.sv
// Bench for kbd_event_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_kbd_event_queue;
  localparam int D     = 3;
  localparam int DEPTH = 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       reset = 1'b1;
  logic       lvl   = 1'b0;
  logic       ack   = 1'b0;
  logic [1:0] typ   = 2'd0;
  logic [7:0] dat   = 8'd0;
  logic [7:0] mouse_x, mouse_y, kbd_data;
  logic       kbd_valid, kbd_osd, overflow;
  logic [D:0] level;

  kbd_event_queue #(.DEPTH_LOG2(D)) dut (
    .clk_sys(clk_sys), .reset(reset), .kbd_mouse_level(lvl),
    .kbd_mouse_type(typ), .kbd_mouse_data(dat),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .kbd_osd(kbd_osd), .kbd_ack(ack),
    .overflow(overflow), .level(level)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event queue plus a dispatcher phase (0 fetch, 1 execute, 2 await ack).
  logic [9:0] mq[$];
  logic [9:0] m_head;
  int         m_stage = 0;
  logic       m_lvl = 1'b0;
  logic [7:0] m_mx = 8'd0, m_my = 8'd0, m_kd = 8'd0;
  logic       m_kv = 1'b0, m_ko = 1'b0, m_ov = 1'b0;
  bit         started = 1'b0;
  bit         m_pushreq;

  always @(posedge clk_sys) begin
    if (reset) begin
      mq.delete();
      m_stage = 0;
      m_mx = 8'd0; m_my = 8'd0; m_kd = 8'd0;
      m_kv = 1'b0; m_ko = 1'b0; m_ov = 1'b0;
      m_lvl = lvl;
      started = 1'b1;
    end else begin
      m_pushreq = (lvl != m_lvl);
      m_lvl = lvl;
      case (m_stage)
        0: if (mq.size() > 0) begin
             m_head = mq.pop_front();
             m_stage = 1;
           end
        1: begin
             if (m_head[9:8] == 2'd0) begin
               m_mx = m_mx + m_head[7:0];
               m_stage = 0;
             end else if (m_head[9:8] == 2'd1) begin
               m_my = m_my + m_head[7:0];
               m_stage = 0;
             end else begin
               m_kd = m_head[7:0];
               m_ko = m_head[8];
               m_kv = 1'b1;
               m_stage = 2;
             end
           end
        default: if (ack) begin
             m_kv = 1'b0;
             m_stage = 0;
           end
      endcase
      if (m_pushreq) begin
        if (mq.size() < DEPTH) mq.push_back({typ, dat});
        else m_ov = 1'b1;
      end
    end
    #1;
    if (started) begin
      chk("model_mouse_x", mouse_x, m_mx);
      chk("model_mouse_y", mouse_y, m_my);
      chk("model_kbd_valid", kbd_valid, m_kv);
      chk("model_kbd_data", kbd_data, m_kd);
      chk("model_kbd_osd", kbd_osd, m_ko);
      chk("model_overflow", overflow, m_ov);
      chk("model_level", level, mq.size());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ev(input logic [1:0] t, input logic [7:0] d);
    typ = t; dat = d; lvl = ~lvl;
    @(negedge clk_sys);
  endtask

  task automatic ack1();
    ack = 1'b1;
    @(negedge clk_sys);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] b;

  initial begin
    tick(2);
    reset = 1'b0;
    chk("rst_level", level, 4'd0);
    chk("rst_mouse_x", mouse_x, 8'd0);
    chk("rst_kbd_valid", kbd_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);

    // mouse X wrap
    ev(2'd0, 8'h05);
    tick(1);
    chk("mx_edge2", mouse_x, 8'h00);
    tick(1);
    chk("mx_edge3", mouse_x, 8'h05);
    ev(2'd0, 8'hFB);
    tick(2);
    chk("mx_wrap", mouse_x, 8'h00);

    // OSD keyboard byte held without ack
    ev(2'd3, 8'h45);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", kbd_valid, 1'b1);
      chk("hold_data", kbd_data, 8'h45);
      chk("hold_osd", kbd_osd, 1'b1);
      tick(1);
    end
    ack1();
    chk("ack_clear", kbd_valid, 1'b0);

    // head-of-line ordering
    ev(2'd2, 8'h20);
    ev(2'd1, 8'h01);
    ev(2'd1, 8'h01);
    ev(2'd1, 8'h01);
    tick(4);
    chk("hol_valid", kbd_valid, 1'b1);
    chk("hol_data", kbd_data, 8'h20);
    chk("hol_osd", kbd_osd, 1'b0);
    chk("hol_my", mouse_y, 8'd0);
    chk("hol_level", level, 4'd3);
    ack1();
    tick(2);
    chk("my_1", mouse_y, 8'd1);
    tick(1);
    chk("my_1_hold", mouse_y, 8'd1);
    tick(1);
    chk("my_2", mouse_y, 8'd2);
    tick(2);
    chk("my_3", mouse_y, 8'd3);

    // overflow with 10 keyboard events
    for (int i = 0; i < 10; i++) begin
      b = 8'h30 + 8'(i);
      ev(2'd2, b);
    end
    tick(3);
    chk("ovf_level", level, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 9; i++) begin
      b = 8'h30 + 8'(i);
      chk("ovf_order_valid", kbd_valid, 1'b1);
      chk("ovf_order_data", kbd_data, b);
      ack1();
      tick(3);
    end
    chk("ovf_drained_valid", kbd_valid, 1'b0);
    chk("ovf_drained_level", level, 4'd0);
    chk("ovf_sticky", overflow, 1'b1);

    // reset while a byte waits, toggling the strobe during reset
    for (int i = 0; i < 5; i++) begin
      b = 8'h60 + 8'(i);
      ev(2'd2, b);
    end
    chk("prerst_level", level, 4'd4);
    chk("prerst_valid", kbd_valid, 1'b1);
    reset = 1'b1;
    lvl = ~lvl;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("rstw_valid", kbd_valid, 1'b0);
    chk("rstw_level", level, 4'd0);
    chk("rstw_my", mouse_y, 8'd0);
    chk("rstw_overflow", overflow, 1'b0);
    tick(4);
    chk("rstw_nopush_level", level, 4'd0);
    chk("rstw_nopush_valid", kbd_valid, 1'b0);

    // full FIFO: push lands on the same edge as a pop
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = 8'h50 + 8'(i);
      ev(2'd2, b);
    end
    chk("full_level", level, 4'd8);
    chk("full_ovf", overflow, 1'b0);
    ack = 1'b1;
    @(negedge clk_sys);
    ack = 1'b0;
    typ = 2'd2; dat = 8'h77; lvl = ~lvl;
    @(negedge clk_sys);
    chk("pushpop_level", level, 4'd8);
    chk("pushpop_ovf", overflow, 1'b0);
    tick(2);
    chk("pushpop_next", kbd_data, 8'h51);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
